// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: RAM handshake state, data word and arbiter FSM state.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

    // Index width for a requester set; a single requester still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, the icache/coherence requesters and the RAM model.
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS = 2
);
    logic [CPUS-1:0]  iREN;
    word_t [CPUS-1:0] iaddr;
    logic [CPUS-1:0]  iwait;
    word_t [CPUS-1:0] iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [CPUS-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   owner_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        idx     = '0;
        found   = 1'b0;
        owner_o = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
            idx = PW'((32'(ptr_i) + i) % CPUS);
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                owner_o = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: coherence data port has priority, icaches round-robin with a
// starvation cap; grants are held per transaction. ARB_PERF_EN adds grant/stall counters.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS       = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
`ifdef ARB_PERF_EN
    ,
    output word_t        perf_dgrants,
    output word_t        perf_igrants,
    output word_t        perf_istall
`endif
);

    localparam int unsigned PW = ptr_width(CPUS);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [PW-1:0] pick;
    logic          pick_vld;
    logic          any_i;
    logic          d_req;
    logic          access;

    assign any_i  = |bus.iREN;
    assign d_req  = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == ACCESS);

    rr_picker #(
        .CPUS (CPUS),
        .PW   (PW)
    ) u_rr_picker (
        .req_i   (bus.iREN),
        .ptr_i   (rr_ptr_q),
        .owner_o (pick),
        .valid_o (pick_vld)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Next state plus the RAM/requester muxing; outputs follow the live grant so an
    // asynchronous reset drops the strobes at once.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        bus.iwait    = '1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = BAD_WORD;
        bus.ramstore = BAD_WORD;

        case (state_q)
            IDLE: begin
                if (d_req && !(starve_q == STARVE_CAP && any_i)) begin
                    state_d = GRANT_D;
                    if (!any_i) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_CAP) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (pick_vld) begin
                    state_d  = GRANT_I;
                    owner_d  = pick;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end

            GRANT_D: begin
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
                bus.dwait    = !access;
                if (!d_req) begin
                    state_d = IDLE;
                end
            end

            GRANT_I: begin
                bus.ramREN          = 1'b1;
                bus.ramaddr         = bus.iaddr[owner_q];
                bus.iload[owner_q]  = bus.ramload;
                bus.iwait[owner_q]  = !access;
                // A withdrawn request abandons the grant without advancing fairness.
                if (!bus.iREN[owner_q]) begin
                    state_d = IDLE;
                end else if (access) begin
                    state_d  = IDLE;
                    rr_ptr_d = PW'((32'(owner_q) + 32'd1) % CPUS);
                    starve_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_EN
    word_t dgrants_q, igrants_q, istall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dgrants_q <= '0;
            igrants_q <= '0;
            istall_q  <= '0;
        end else begin
            if (state_q == IDLE && state_d == GRANT_D) begin
                dgrants_q <= dgrants_q + 32'd1;
            end
            if (state_q == GRANT_I && access && bus.iREN[owner_q]) begin
                igrants_q <= igrants_q + 32'd1;
            end
            if (any_i && state_q != GRANT_I) begin
                istall_q <= istall_q + 32'd1;
            end
        end
    end

    assign perf_dgrants = dgrants_q;
    assign perf_igrants = igrants_q;
    assign perf_istall  = istall_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed vector bench for ram_arbiter: table of per-cycle stimulus/expectations plus
// hand sequences for starvation and mid-grant reset.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam word_t BAD = 32'hBAD1BAD1;

    logic CLK = 1'b0;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    ram_arbiter_if #(.CPUS(2)) bus ();

`ifdef ARB_PERF_EN
    word_t perf_dgrants, perf_igrants, perf_istall;
`endif

    ram_arbiter #(
        .CPUS       (2),
        .STARVE_MAX (4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef ARB_PERF_EN
        ,
        .perf_dgrants (perf_dgrants),
        .perf_igrants (perf_igrants),
        .perf_istall  (perf_istall)
`endif
    );

    typedef struct {
        logic [1:0] iren;
        logic       dren;
        logic       dwen;
        word_t      daddr;
        word_t      dstore;
        word_t      rload;
        ramstate_t  rs;
        logic       eren;
        logic       ewen;
        word_t      eaddr;
        word_t      estore;
        logic [1:0] eiw;
        logic       edw;
        word_t      eil0;
        word_t      eil1;
        word_t      edl;
    } vec_t;

    function automatic vec_t mk(logic [1:0] iren, logic dren, logic dwen, word_t daddr,
                                word_t dstore, word_t rload, ramstate_t rs,
                                logic eren, logic ewen, word_t eaddr, word_t estore,
                                logic [1:0] eiw, logic edw, word_t eil0, word_t eil1,
                                word_t edl);
        vec_t v;
        v.iren = iren;  v.dren = dren;  v.dwen = dwen;  v.daddr = daddr;
        v.dstore = dstore;  v.rload = rload;  v.rs = rs;
        v.eren = eren;  v.ewen = ewen;  v.eaddr = eaddr;  v.estore = estore;
        v.eiw = eiw;  v.edw = edw;  v.eil0 = eil0;  v.eil1 = eil1;  v.edl = edl;
        return v;
    endfunction

    // Inputs with the outputs expected while the arbiter sits in IDLE.
    function automatic vec_t mki(logic [1:0] iren, logic dren, logic dwen, word_t daddr,
                                 word_t dstore, word_t rload, ramstate_t rs);
        return mk(iren, dren, dwen, daddr, dstore, rload, rs,
                  1'b0, 1'b0, BAD, BAD, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0);
    endfunction

    task automatic drive(input vec_t v);
        bus.iREN     = v.iren;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.daddr    = v.daddr;
        bus.dstore   = v.dstore;
        bus.ramload  = v.rload;
        bus.ramstate = v.rs;
    endtask

    task automatic check(input vec_t v, input string name);
        logic [164:0] act, exp;
        act = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait,
               bus.iload[1], bus.iload[0], bus.dload};
        exp = {v.eren, v.ewen, v.eaddr, v.estore, v.eiw, v.edw, v.eil1, v.eil0, v.edl};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b il1=%h il0=%h dl=%h want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b il1=%h il0=%h dl=%h",
                     name, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait,
                     bus.dwait, bus.iload[1], bus.iload[0], bus.dload,
                     v.eren, v.ewen, v.eaddr, v.estore, v.eiw, v.edw, v.eil1, v.eil0, v.edl);
        end
    endtask

    // Drive mid-cycle, check before the next edge, then advance one clock.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        #1;
        check(v, name);
        @(posedge CLK);
        #2;
    endtask

    vec_t tbl[21];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mki(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111, FREE);
        tbl[1]  = mk (2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111, BUSY,
                      1'b1, 1'b0, 32'h40, BAD, 2'b11, 1'b1, 32'h11111111, 32'h0, 32'h0);
        tbl[2]  = mk (2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE0040, ACCESS,
                      1'b1, 1'b0, 32'h40, BAD, 2'b10, 1'b1, 32'hCAFE0040, 32'h0, 32'h0);
        tbl[3]  = mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[4]  = mki(2'b11, 1'b1, 1'b0, 32'h200, 32'h5555, 32'h0, FREE);
        tbl[5]  = mk (2'b11, 1'b1, 1'b0, 32'h200, 32'h5555, 32'hD0D0D0D0, ACCESS,
                      1'b1, 1'b0, 32'h200, 32'h5555, 2'b11, 1'b0, 32'h0, 32'h0, 32'hD0D0D0D0);
        tbl[6]  = mk (2'b11, 1'b0, 1'b0, 32'h200, 32'h5555, 32'h0, FREE,
                      1'b0, 1'b0, 32'h200, 32'h5555, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0);
        tbl[7]  = mki(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[8]  = mk (2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h80808080, ACCESS,
                      1'b1, 1'b0, 32'h80, BAD, 2'b01, 1'b1, 32'h0, 32'h80808080, 32'h0);
        tbl[9]  = mki(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[10] = mk (2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40404040, ACCESS,
                      1'b1, 1'b0, 32'h40, BAD, 2'b10, 1'b1, 32'h40404040, 32'h0, 32'h0);
        tbl[11] = mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[12] = mki(2'b00, 1'b0, 1'b1, 32'h100, 32'hAAAA0001, 32'h0, FREE);
        tbl[13] = mk (2'b00, 1'b0, 1'b1, 32'h100, 32'hAAAA0001, 32'h0, ACCESS,
                      1'b0, 1'b1, 32'h100, 32'hAAAA0001, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        tbl[14] = mk (2'b10, 1'b0, 1'b1, 32'h104, 32'hAAAA0002, 32'h0, ACCESS,
                      1'b0, 1'b1, 32'h104, 32'hAAAA0002, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        tbl[15] = mk (2'b10, 1'b0, 1'b0, 32'h104, 32'hAAAA0002, 32'h0, FREE,
                      1'b0, 1'b0, 32'h104, 32'hAAAA0002, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0);
        tbl[16] = mki(2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[17] = mk (2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77, ERROR,
                      1'b1, 1'b0, 32'h80, BAD, 2'b11, 1'b1, 32'h0, 32'h77, 32'h0);
        tbl[18] = mki(2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
        tbl[19] = mk (2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, ACCESS,
                      1'b1, 1'b0, 32'h80, BAD, 2'b01, 1'b1, 32'h0, 32'h12345678, 32'h0);
        tbl[20] = mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);

        bus.iaddr[0] = 32'h40;
        bus.iaddr[1] = 32'h80;
        nRST = 1'b0;
        drive(mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE));
        #1;
        check(mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE), "reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #2;

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Four back-to-back data grants with icache 1 waiting; the fifth goes to icache 1.
        for (int k = 0; k < 4; k++) begin
            word_t a;
            a = 32'h300 + 32'(k * 4);
            apply(mki(2'b10, 1'b1, 1'b0, a, 32'h0, 32'h0, FREE), $sformatf("starve_idle%0d", k));
            apply(mk(2'b10, 1'b1, 1'b0, a, 32'h0, 32'h0, ACCESS,
                     1'b1, 1'b0, a, 32'h0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0),
                  $sformatf("starve_dgrant%0d", k));
            apply(mk(2'b10, 1'b0, 1'b0, a, 32'h0, 32'h0, FREE,
                     1'b0, 1'b0, a, 32'h0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0),
                  $sformatf("starve_drop%0d", k));
        end
        apply(mki(2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, FREE), "starve_idle4");
        apply(mk(2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 32'hBEEF, ACCESS,
                 1'b1, 1'b0, 32'h80, BAD, 2'b01, 1'b1, 32'h0, 32'hBEEF, 32'h0), "starve_igrant");
        apply(mki(2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, FREE), "starve_cleared_idle");
        apply(mk(2'b10, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, FREE,
                 1'b1, 1'b0, 32'h400, 32'h0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0), "starve_cleared_dgrant");
        apply(mk(2'b10, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, FREE,
                 1'b0, 1'b0, 32'h400, 32'h0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0), "starve_cleared_drop");
        apply(mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE), "quiet");

        // Reset in the middle of an icache grant, then a simultaneous read+write request.
        apply(mki(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE), "rst_pre_idle");
        drive(mki(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BUSY));
        #1;
        check(mk(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BUSY,
                 1'b1, 1'b0, 32'h40, BAD, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0), "rst_in_grant");
        nRST = 1'b0;
        #1;
        check(mki(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BUSY), "rst_async_drop");
        #2;
        nRST = 1'b1;
        drive(mki(2'b00, 1'b1, 1'b1, 32'h500, 32'h99, 32'h0, FREE));
        #1;
        check(mki(2'b00, 1'b1, 1'b1, 32'h500, 32'h99, 32'h0, FREE), "rst_released_idle");
        @(posedge CLK);
        #2;
        apply(mk(2'b00, 1'b1, 1'b1, 32'h500, 32'h99, 32'h0, FREE,
                 1'b0, 1'b1, 32'h500, 32'h99, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0), "rw_both_wen_wins");
        apply(mk(2'b00, 1'b0, 1'b0, 32'h500, 32'h99, 32'h0, FREE,
                 1'b0, 1'b0, 32'h500, 32'h99, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0), "rw_drop");
        apply(mki(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE), "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
